// File: rtl/br_puf_pkg.sv
// ---------------------------------------------------------------------------
// br_puf_pkg
// Shared definitions for the bistable-ring PUF reader:
//   PUF_WIDTH : number of rings in the array (response width)
//   state_t   : reader FSM states
//   cnt_w()   : width of a per-bit vote counter able to hold 0..num_evals
// ---------------------------------------------------------------------------
package br_puf_pkg;

  localparam int PUF_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // A counter that must represent every value from 0 to num_evals inclusive.
  function automatic int cnt_w(input int num_evals);
    return $clog2(num_evals + 1);
  endfunction

endpackage

// File: rtl/br_puf_reader_vote.sv
// ---------------------------------------------------------------------------
// puf_bit_vote
// One ring's worth of reader datapath: a 2-flop synchronizer for the
// asynchronous ring output, a vote counter accumulating one sample per
// evaluation, and the majority / instability decode of that counter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the vote counter (new challenge accepted)
//   sample     : add the synchronized ring value to the counter this cycle
//   puf_bit    : raw ring output, asynchronous to clk
//   vote       : majority result (count > NUM_EVALS/2)
//   unstable   : votes were not unanimous
// ---------------------------------------------------------------------------
module puf_bit_vote
  import br_puf_pkg::*;
#(
  parameter int NUM_EVALS = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic sample,
  input  logic puf_bit,
  output logic vote,
  output logic unstable
);

  localparam int CNT_W = cnt_w(NUM_EVALS);
  localparam logic [CNT_W-1:0] ALL_VOTES  = CNT_W'(NUM_EVALS);
  localparam logic [CNT_W-1:0] HALF_VOTES = CNT_W'(NUM_EVALS / 2);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] count;

  // NOTE: the synchronizer flops carry no reset; they are flushed by the
  // settle window long before anyone looks at them, and leaving the reset off
  // keeps the first stage a plain metastability-catching flop.
  always_ff @(posedge clk) begin
    sync_1 <= puf_bit;
    sync_2 <= sync_1;
  end

  // At most NUM_EVALS samples land between clears, so the counter cannot wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (sample) begin
      count <= count + CNT_W'(sync_2);
    end
  end

  assign vote     = (count > HALF_VOTES);
  assign unstable = (count != '0) && (count != ALL_VOTES);

endmodule

// File: rtl/br_puf_reader.sv
// ---------------------------------------------------------------------------
// br_puf_reader
// Drives a challenge onto the 32-ring bistable-ring PUF array, runs
// NUM_EVALS reset/settle/sample evaluations and returns the majority-voted
// response together with a per-bit instability mask.
// Parameters:
//   RESET_CYCLES  : cycles puf_reset is held per evaluation (1..255)
//   SETTLE_CYCLES : cycles after reset release before sampling (4..65535)
//   NUM_EVALS     : evaluations per challenge, odd, 1..15
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   req_valid/req_ready/req_challenge   : challenge request port
//   puf_challenge, puf_reset            : registered drive to the array
//   puf_rsp                             : raw ring outputs (asynchronous)
//   rsp_valid/rsp_ready                 : response port handshake
//   rsp_data, rsp_unstable              : voted response and instability mask
//   busy                                : high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module br_puf_reader
  import br_puf_pkg::*;
#(
  parameter int RESET_CYCLES  = 8,
  parameter int SETTLE_CYCLES = 64,
  parameter int NUM_EVALS     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [PUF_WIDTH-1:0] req_challenge,
  output logic [PUF_WIDTH-1:0] puf_challenge,
  output logic                 puf_reset,
  input  logic [PUF_WIDTH-1:0] puf_rsp,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [PUF_WIDTH-1:0] rsp_data,
  output logic [PUF_WIDTH-1:0] rsp_unstable,
  output logic                 busy
);

  localparam int CYC_W  = 16;
  localparam int EVAL_W = 4;

  localparam logic [CYC_W-1:0]  RST_LAST    = CYC_W'(RESET_CYCLES - 1);
  localparam logic [CYC_W-1:0]  SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [EVAL_W-1:0] EVAL_LAST   = EVAL_W'(NUM_EVALS - 1);

  state_t            state;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [EVAL_W-1:0] eval_cnt;
  logic              accept;
  logic              sample;

  assign accept = (state == ST_IDLE) && req_valid && req_ready;
  assign sample = (state == ST_SAMPLE);

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every flop in this block samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      req_ready     <= 1'b0;
      puf_reset     <= 1'b1;
      puf_challenge <= '0;
      rsp_valid     <= 1'b0;
      busy          <= 1'b0;
      cyc_cnt       <= '0;
      eval_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          puf_reset <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          if (accept) begin
            puf_challenge <= req_challenge;
            cyc_cnt       <= '0;
            eval_cnt      <= '0;
            req_ready     <= 1'b0;
            busy          <= 1'b1;
            state         <= ST_RST;
          end
        end

        // Array held in reset; puf_reset drops on the last RST edge.
        ST_RST: begin
          if (cyc_cnt == RST_LAST) begin
            cyc_cnt   <= '0;
            puf_reset <= 1'b0;
            state     <= ST_SETTLE;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        // Rings race to a stable state while the synchronizer fills up.
        ST_SETTLE: begin
          if (cyc_cnt == SETTLE_LAST) begin
            cyc_cnt <= '0;
            state   <= ST_SAMPLE;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        // The per-bit counters take their vote on this edge (see sample).
        ST_SAMPLE: begin
          eval_cnt  <= eval_cnt + 1'b1;
          puf_reset <= 1'b1;
          if (eval_cnt == EVAL_LAST) begin
            rsp_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            state <= ST_RST;
          end
        end

        // Response held until the consumer takes it.
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar i = 0; i < PUF_WIDTH; i++) begin : g_bit
    puf_bit_vote #(
      .NUM_EVALS (NUM_EVALS)
    ) u_vote (
      .clk      (clk),
      .reset    (reset),
      .clear    (accept),
      .sample   (sample),
      .puf_bit  (puf_rsp[i]),
      .vote     (rsp_data[i]),
      .unstable (rsp_unstable[i])
    );
  end

endmodule

// File: tb/tb_br_puf_reader.sv
// ---------------------------------------------------------------------------
// tb_br_puf_reader
// Self-checking bench for br_puf_reader. Two instances share the same
// stimulus: one with default parameters and one with the minimal set
// (NUM_EVALS=1, RESET_CYCLES=2, SETTLE_CYCLES=4); use_min selects which one
// is observed. The reference model records puf_rsp at every rising edge and
// derives the expected response from the values present two edges before
// each sample-exit edge, i.e. edge acc + k*(R+S+1) - 2 for evaluation k.
// ---------------------------------------------------------------------------
module tb_br_puf_reader;

  localparam int D_R = 8;
  localparam int D_S = 64;
  localparam int D_N = 5;
  localparam int M_R = 2;
  localparam int M_S = 4;
  localparam int M_N = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [31:0] req_challenge = '0;
  logic [31:0] puf_rsp = '0;

  logic        d_req_ready, d_puf_reset, d_rsp_valid, d_busy;
  logic [31:0] d_puf_challenge, d_rsp_data, d_rsp_unstable;
  logic        m_req_ready, m_puf_reset, m_rsp_valid, m_busy;
  logic [31:0] m_puf_challenge, m_rsp_data, m_rsp_unstable;

  logic        use_min = 1'b0;
  logic        o_req_ready, o_puf_reset, o_rsp_valid, o_busy;
  logic [31:0] o_puf_challenge, o_rsp_data, o_rsp_unstable;

  assign o_req_ready     = use_min ? m_req_ready     : d_req_ready;
  assign o_puf_reset     = use_min ? m_puf_reset     : d_puf_reset;
  assign o_rsp_valid     = use_min ? m_rsp_valid     : d_rsp_valid;
  assign o_busy          = use_min ? m_busy          : d_busy;
  assign o_puf_challenge = use_min ? m_puf_challenge : d_puf_challenge;
  assign o_rsp_data      = use_min ? m_rsp_data      : d_rsp_data;
  assign o_rsp_unstable  = use_min ? m_rsp_unstable  : d_rsp_unstable;

  always #5 clk = ~clk;

  br_puf_reader #(.RESET_CYCLES(D_R), .SETTLE_CYCLES(D_S), .NUM_EVALS(D_N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(d_req_ready), .req_challenge(req_challenge),
    .puf_challenge(d_puf_challenge), .puf_reset(d_puf_reset), .puf_rsp(puf_rsp),
    .rsp_valid(d_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(d_rsp_data), .rsp_unstable(d_rsp_unstable), .busy(d_busy)
  );

  br_puf_reader #(.RESET_CYCLES(M_R), .SETTLE_CYCLES(M_S), .NUM_EVALS(M_N)) dut_min (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(m_req_ready), .req_challenge(req_challenge),
    .puf_challenge(m_puf_challenge), .puf_reset(m_puf_reset), .puf_rsp(puf_rsp),
    .rsp_valid(m_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(m_rsp_data), .rsp_unstable(m_rsp_unstable), .busy(m_busy)
  );

  function automatic int p_r();
    return use_min ? M_R : D_R;
  endfunction
  function automatic int p_n();
    return use_min ? M_N : D_N;
  endfunction
  function automatic int per();
    return use_min ? (M_R + M_S + 1) : (D_R + D_S + 1);
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- edge history: value of puf_rsp seen by edge number e ----
  logic [31:0] hist [int];
  int cyc = 0;
  always @(posedge clk) begin
    hist[cyc] = puf_rsp;
    cyc = cyc + 1;
  end

  // ---- array model ----
  typedef enum {M_CONST, M_RAND, M_SCRIPT} mode_t;
  mode_t       mode = M_CONST;
  logic [31:0] const_val = '0;
  logic [31:0] script [1:15];
  int          acc = -1000;

  // Drives the value that the next edge (index cyc) will see.
  always @(negedge clk) begin
    int e;
    int k;
    e = cyc;
    case (mode)
      M_CONST: puf_rsp = const_val;
      M_RAND:  puf_rsp = $urandom;
      default: begin
        puf_rsp = $urandom;
        if (e > acc && ((e - acc + 2) % per()) == 0) begin
          k = (e - acc + 2) / per();
          if (k >= 1 && k <= p_n()) puf_rsp = script[k];
        end
      end
    endcase
  end

  task automatic model(input int a, output logic [31:0] exp_d, output logic [31:0] exp_u);
    int cnt;
    logic [31:0] v;
    exp_d = '0;
    exp_u = '0;
    for (int b = 0; b < 32; b++) begin
      cnt = 0;
      for (int k = 1; k <= p_n(); k++) begin
        v = hist[a + k * per() - 2];
        cnt += int'(v[b]);
      end
      exp_d[b] = (2 * cnt > p_n());
      exp_u[b] = (cnt != 0) && (cnt != p_n());
    end
  endtask

  task automatic start_txn(input logic [31:0] ch);
    int guard;
    guard = 0;
    @(negedge clk);
    while (o_req_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_before_accept", o_req_ready, 1);
    req_valid     = 1'b1;
    req_challenge = ch;
    acc           = cyc;
    @(negedge clk);
    req_valid     = 1'b0;
    req_challenge = $urandom;
    check("puf_challenge_after_accept", o_puf_challenge, ch);
    check("busy_after_accept", o_busy, 1);
    check("req_ready_after_accept", o_req_ready, 0);
  endtask

  task automatic finish_txn(input logic [31:0] ch, input int hold);
    int lim;
    int last;
    int off;
    bit seen;
    logic [31:0] exp_d, exp_u;
    lim  = acc + p_n() * per();
    seen = 1'b0;
    last = cyc - 1;
    while (!seen && (cyc - 1) <= lim + 5) begin
      last = cyc - 1;
      off  = last - acc;
      if (o_rsp_valid === 1'b1) begin
        seen = 1'b1;
      end else begin
        check("puf_reset_phase", o_puf_reset, ((off % per()) < p_r()) ? 32'd1 : 32'd0);
        check("puf_challenge_held", o_puf_challenge, ch);
        @(negedge clk);
      end
    end
    check("rsp_valid_seen", seen, 1);
    check("rsp_valid_edge", last - acc, lim - acc);
    model(acc, exp_d, exp_u);
    check("rsp_data", o_rsp_data, exp_d);
    check("rsp_unstable", o_rsp_unstable, exp_u);
    check("puf_reset_done", o_puf_reset, 1);
    check("busy_done", o_busy, 1);
    // Backpressure with a competing request that must be refused.
    req_valid     = (hold > 0);
    req_challenge = ~ch;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", o_rsp_valid, 1);
      check("bp_rsp_data", o_rsp_data, exp_d);
      check("bp_rsp_unstable", o_rsp_unstable, exp_u);
      check("bp_req_ready", o_req_ready, 0);
      check("bp_puf_challenge", o_puf_challenge, ch);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_hs_rsp_valid", o_rsp_valid, 0);
    check("post_hs_req_ready", o_req_ready, 1);
    check("post_hs_busy", o_busy, 0);
    check("post_hs_puf_challenge", o_puf_challenge, ch);
  endtask

  task automatic run_txn(input logic [31:0] ch, input int hold);
    start_txn(ch);
    finish_txn(ch, hold);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ch;

    // ---- reset values on both instances ----
    repeat (3) @(negedge clk);
    check("rst_d_req_ready", d_req_ready, 0);
    check("rst_d_puf_reset", d_puf_reset, 1);
    check("rst_d_puf_challenge", d_puf_challenge, 0);
    check("rst_d_rsp_valid", d_rsp_valid, 0);
    check("rst_d_rsp_data", d_rsp_data, 0);
    check("rst_d_rsp_unstable", d_rsp_unstable, 0);
    check("rst_d_busy", d_busy, 0);
    check("rst_m_req_ready", m_req_ready, 0);
    check("rst_m_busy", m_busy, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_d_req_ready", d_req_ready, 1);
    check("rel_m_req_ready", m_req_ready, 1);
    check("rel_d_puf_reset", d_puf_reset, 1);

    // ---- stable response ----
    mode = M_CONST;
    const_val = 32'hA5A5_5A5A;
    run_txn(32'h1234_5678, 0);

    // ---- noisy bit 0: ones on evals 1 and 3 ----
    mode = M_SCRIPT;
    for (int k = 1; k <= 15; k++) script[k] = '0;
    script[1] = 32'h1;
    script[3] = 32'h1;
    run_txn($urandom, 0);

    // ---- noisy bit 0: ones on evals 1, 3 and 5 ----
    script[5] = 32'h1;
    run_txn($urandom, 0);

    // ---- backpressure ----
    mode = M_CONST;
    const_val = $urandom;
    run_txn($urandom, 10);

    // ---- random evaluation vectors and free-running noise ----
    for (int t = 0; t < 2; t++) begin
      mode = M_SCRIPT;
      for (int k = 1; k <= 15; k++) script[k] = $urandom;
      run_txn($urandom, $urandom_range(0, 3));
      mode = M_RAND;
      run_txn($urandom, $urandom_range(0, 3));
    end

    // ---- reset during SETTLE of eval 2 ----
    mode = M_CONST;
    const_val = 32'h0000_FFFF;
    ch = $urandom | 32'h1;
    start_txn(ch);
    repeat (per() + p_r() + 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_puf_reset", o_puf_reset, 1);
    check("midrst_busy", o_busy, 0);
    check("midrst_rsp_valid", o_rsp_valid, 0);
    check("midrst_puf_challenge", o_puf_challenge, 0);
    check("midrst_req_ready", o_req_ready, 0);
    @(negedge clk);
    check("midrst_req_ready_rel", o_req_ready, 1);
    const_val = 32'hFFFF_0000;
    run_txn($urandom, 0);
    check("midrst_no_carry_data", o_rsp_data, 32'hFFFF_0000);

    // ---- minimal parameter instance ----
    pulse_reset();
    use_min = 1'b1;
    mode = M_SCRIPT;
    for (int t = 0; t < 4; t++) begin
      script[1] = $urandom;
      run_txn($urandom, $urandom_range(0, 2));
      check("min_unstable_zero", o_rsp_unstable, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
